// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write tracker for in-order issue.
// Each architectural register 1..31 carries a saturating CNT_W-bit count of
// issued-but-not-retired writes; busy_o flags nonzero counts and stall_o
// blocks an instruction that reads a busy source or would overflow its
// destination counter. Register 0 is never tracked.
// Optional feature: define SCB_WB_BYPASS_EN to let a same-cycle write-back
// of the last pending write clear a source hazard (register file forwarding).
module reg_scoreboard #(
  parameter int unsigned CNT_W = 2
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        issue_valid_i,
  input  logic        issue_regwrite_i,
  input  logic [4:0]  issue_rd_addr_i,
  input  logic        rs1_used_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic        rs2_used_i,
  input  logic [4:0]  rs2_addr_i,
  input  logic        wb_RegWrite_i,
  input  logic [4:0]  wb_rd_addr_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic [31:0] busy_o,
  output logic        overflow_err_o,
  output logic        underflow_err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [31:0]      busy_q;
  logic [31:0]      busy_d;
  logic             ovf_q, unf_q;
  logic             ovf_set, unf_set;
  logic             rs1_haz, rs2_haz, rd_full, hazard, issue_accept;

  // Hazard detection from registered state and current-cycle inputs
  always_comb begin
    rs1_haz = rs1_used_i & busy_q[rs1_addr_i];
    rs2_haz = rs2_used_i & busy_q[rs2_addr_i];
`ifdef SCB_WB_BYPASS_EN
    if (wb_RegWrite_i && (wb_rd_addr_i == rs1_addr_i) && (cnt_q[rs1_addr_i] == CNT_ONE))
      rs1_haz = 1'b0;
    if (wb_RegWrite_i && (wb_rd_addr_i == rs2_addr_i) && (cnt_q[rs2_addr_i] == CNT_ONE))
      rs2_haz = 1'b0;
`endif
    rd_full      = issue_regwrite_i & (issue_rd_addr_i != 5'd0) &
                   (cnt_q[issue_rd_addr_i] == CNT_MAX);
    hazard       = rs1_haz | rs2_haz | rd_full;
    stall_o      = rst_n & issue_valid_i & hazard & ~flush_i;
    issue_accept = rst_n & issue_valid_i & ~hazard & ~flush_i;
  end

  // Next counter values and error events for each tracked register
  always_comb begin
    logic inc, dec;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    busy_d  = '0;
    inc     = 1'b0;
    dec     = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    cnt_d[0] = '0;
    if (flush_i) begin
      for (int unsigned i = 1; i < 32; i++) begin
        cnt_d[i] = '0;
      end
    end else begin
      for (int unsigned i = 1; i < 32; i++) begin
        inc = issue_accept & issue_regwrite_i & (issue_rd_addr_i == 5'(i));
        dec = wb_RegWrite_i & (wb_rd_addr_i == 5'(i));
        if (inc && dec) begin
          // Net-zero update; a retire against an empty counter is still an error
          if (cnt_q[i] == '0) unf_set = 1'b1;
        end else if (inc) begin
          if (cnt_q[i] == CNT_MAX) ovf_set = 1'b1;
          else                     cnt_d[i] = cnt_q[i] + CNT_ONE;
        end else if (dec) begin
          if (cnt_q[i] == '0) unf_set = 1'b1;
          else                cnt_d[i] = cnt_q[i] - CNT_ONE;
        end
      end
    end
    for (int unsigned i = 1; i < 32; i++) begin
      busy_d[i] = (cnt_d[i] != '0);
    end
  end

  // Counter, busy and sticky error state
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) begin
        cnt_q[i] <= '0;
      end
      busy_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 32; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      busy_q <= busy_d;
      ovf_q  <= ovf_q | ovf_set;
      unf_q  <= unf_q | unf_set;
    end
  end

  assign busy_o          = busy_q;
  assign overflow_err_o  = ovf_q;
  assign underflow_err_o = unf_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios followed by
// random traffic, all compared against a per-register pending-count model.
module tb_reg_scoreboard;

  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        issue_valid_i, issue_regwrite_i;
  logic [4:0]  issue_rd_addr_i;
  logic        rs1_used_i, rs2_used_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i;
  logic        wb_RegWrite_i;
  logic [4:0]  wb_rd_addr_i;
  logic        flush_i;
  logic        stall_o;
  logic [31:0] busy_o;
  logic        overflow_err_o, underflow_err_o;

  int total = 0;
  int bad   = 0;

  int m_cnt [32];
  bit m_ovf, m_unf;

  reg_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk_i            (clk_i),
    .rst_n            (rst_n),
    .issue_valid_i    (issue_valid_i),
    .issue_regwrite_i (issue_regwrite_i),
    .issue_rd_addr_i  (issue_rd_addr_i),
    .rs1_used_i       (rs1_used_i),
    .rs1_addr_i       (rs1_addr_i),
    .rs2_used_i       (rs2_used_i),
    .rs2_addr_i       (rs2_addr_i),
    .wb_RegWrite_i    (wb_RegWrite_i),
    .wb_rd_addr_i     (wb_rd_addr_i),
    .flush_i          (flush_i),
    .stall_o          (stall_o),
    .busy_o           (busy_o),
    .overflow_err_o   (overflow_err_o),
    .underflow_err_o  (underflow_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit iv, input bit rw, input int rd,
                       input bit u1, input int r1, input bit u2, input int r2,
                       input bit wbw, input int wbrd, input bit fl);
    issue_valid_i    = iv;
    issue_regwrite_i = rw;
    issue_rd_addr_i  = 5'(rd);
    rs1_used_i       = u1;
    rs1_addr_i       = 5'(r1);
    rs2_used_i       = u2;
    rs2_addr_i       = 5'(r2);
    wb_RegWrite_i    = wbw;
    wb_rd_addr_i     = 5'(wbrd);
    flush_i          = fl;
  endtask

  function automatic bit src_hazard(input bit used, input int r);
    bit h;
    h = used && (r != 0) && (m_cnt[r] > 0);
`ifdef SCB_WB_BYPASS_EN
    if (wb_RegWrite_i && (int'(wb_rd_addr_i) == r) && (m_cnt[r] == 1)) h = 0;
`endif
    return h;
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b;
    b = '0;
    for (int i = 1; i < 32; i++) if (m_cnt[i] > 0) b[i] = 1'b1;
    return b;
  endfunction

  // One clock: check stall combinationally, advance model, check registered outputs
  task automatic cyc(input string tag);
    bit haz, exp_stall, acc, inc, dec;
    int rd, wr;
    #1;
    haz = src_hazard(rs1_used_i, int'(rs1_addr_i)) |
          src_hazard(rs2_used_i, int'(rs2_addr_i)) |
          (issue_regwrite_i && issue_rd_addr_i != 0 && m_cnt[issue_rd_addr_i] == MAXC);
    exp_stall = rst_n && issue_valid_i && haz && !flush_i;
    acc       = rst_n && issue_valid_i && !haz && !flush_i;
    check({tag, ".stall"}, {31'd0, stall_o}, {31'd0, exp_stall});
    rd = int'(issue_rd_addr_i);
    wr = int'(wb_rd_addr_i);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_ovf = 0;
      m_unf = 0;
    end else if (flush_i) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        inc = acc && issue_regwrite_i && rd == i;
        dec = wb_RegWrite_i && wr == i;
        if (inc && dec) begin
          if (m_cnt[i] == 0) m_unf = 1;
        end else if (inc) begin
          if (m_cnt[i] == MAXC) m_ovf = 1; else m_cnt[i]++;
        end else if (dec) begin
          if (m_cnt[i] == 0) m_unf = 1; else m_cnt[i]--;
        end
      end
    end
    @(posedge clk_i);
    #1;
    check({tag, ".busy"}, busy_o, m_busy());
    check({tag, ".ovf"}, {31'd0, overflow_err_o}, {31'd0, m_ovf});
    check({tag, ".unf"}, {31'd0, underflow_err_o}, {31'd0, m_unf});
  endtask

  initial begin
    int rd, r1, r2, wbrd;
    bit iv, rw, u1, u2, wbw, fl;

    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_ovf = 0;
    m_unf = 0;

    // Reset with junk inputs applied: nothing counted, stall suppressed
    rst_n = 1'b0;
    drive(1, 1, 5, 1, 5, 1, 6, 1, 9, 0);
    @(posedge clk_i);
    #1;
    cyc("rst0");
    drive(1, 1, 7, 0, 0, 0, 0, 1, 3, 1);
    cyc("rst1");
    check("rst.busy_zero", busy_o, 32'h0);
    rst_n = 1'b1;

    // Issue rd=5, then a reader of r5 must stall
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    cyc("iss5");
    check("iss5.busy_const", busy_o, 32'h0000_0020);
    drive(1, 0, 0, 1, 5, 0, 0, 0, 0, 0);
    cyc("raw5");

    // Write-back of r5 in the same cycle as a reader of r5
    drive(1, 0, 0, 1, 5, 0, 0, 1, 5, 0);
`ifdef SCB_WB_BYPASS_EN
    #1;
    check("bypass.stall_const", {31'd0, stall_o}, 32'd0);
`else
    #1;
    check("nobypass.stall_const", {31'd0, stall_o}, 32'd1);
`endif
    cyc("wb5");
    check("wb5.busy5_clear", {31'd0, busy_o[5]}, 32'd0);

    // Saturation: three writes to r7 fill the counter, the fourth stalls
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
      cyc("fill7");
    end
    drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("full7.stall_const", {31'd0, stall_o}, 32'd1);
    cyc("full7");
    check("full7.ovf_const", {31'd0, overflow_err_o}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
      cyc("drain7");
    end

    // Register 0 never tracked
    drive(1, 1, 0, 1, 0, 1, 0, 0, 0, 0);
    cyc("r0a");
    drive(1, 1, 0, 1, 0, 0, 0, 1, 0, 0);
    cyc("r0b");
    check("r0.busy_const", busy_o, 32'h0);

    // Underflow on retire of an idle register, sticky
    drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    cyc("unf9");
    check("unf9.flag_const", {31'd0, underflow_err_o}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("unf9.hold0");
    cyc("unf9.hold1");

    // Flush discards pending writes and overrides a same-cycle issue
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    cyc("iss3");
    drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
    cyc("iss4");
    drive(1, 1, 6, 1, 3, 1, 4, 0, 0, 1);
    #1;
    check("flush.stall_const", {31'd0, stall_o}, 32'd0);
    cyc("flush");
    check("flush.busy_const", busy_o, 32'h0);

    // Reset clears error flags; discarded writes later underflow normally
    drive(1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    cyc("iss2");
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("midrst");
    check("midrst.unf_const", {31'd0, underflow_err_o}, 32'd0);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 2, 0);
    cyc("late2");
    check("late2.unf_const", {31'd0, underflow_err_o}, 32'd1);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("clr");
    rst_n = 1'b1;

    // Random traffic on a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      iv  = ($urandom % 4) != 0;
      rw  = ($urandom % 4) != 0;
      rd  = int'($urandom % 8);
      u1  = ($urandom % 2) != 0;
      r1  = int'($urandom % 8);
      u2  = ($urandom % 3) == 0;
      r2  = int'($urandom % 8);
      wbw = ($urandom % 3) == 0;
      wbrd = int'($urandom % 10);
      if (wbw && ($urandom % 4) != 0) begin
        for (int t = 0; t < 8; t++) begin
          int c;
          c = int'($urandom % 8);
          if (m_cnt[c] > 0) begin
            wbrd = c;
            break;
          end
        end
      end
      if (iv && rw && wbw && wbrd == rd) wbw = 0;
      fl = ($urandom % 25) == 0;
      rst_n = ($urandom % 60) != 0;
      drive(iv, rw, rd, u1, r1, u2, r2, wbw, wbrd, fl);
      cyc("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter CNT_W, default 2, width of each per-register pending-write counter (MAX = 2^CNT_W-1).
REQ-002 clk_i  input  1  system clock; all state updates on posedge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 issue_valid_i  input  1  decode presents an instruction this cycle.
REQ-005 issue_regwrite_i  input  1  presented instruction writes a destination register.
REQ-006 issue_rd_addr_i  input  5  destination index of presented instruction.
REQ-007 rs1_used_i / rs2_used_i  input  1 each  presented instruction reads rs1 / rs2.
REQ-008 rs1_addr_i / rs2_addr_i  input  5 each  source indices of presented instruction.
REQ-009 wb_RegWrite_i  input  1  write-back stage writes the register file this cycle.
REQ-010 wb_rd_addr_i  input  5  write-back destination index.
REQ-011 flush_i  input  1  pipeline flush; all in-flight writes discarded.
REQ-012 stall_o  output  1  combinational; presented instruction must not issue.
REQ-013 busy_o  output  32  registered; bit n = counter n nonzero.
REQ-014 overflow_err_o / underflow_err_o  output  1 each  sticky error flags.

Function
REQ-015 Register 0 is never tracked: counter 0 constant zero, busy_o[0] = 0, issues/retires to index 0 ignored.
REQ-016 Hazard = (rs1_used_i & busy[rs1_addr_i]) | (rs2_used_i & busy[rs2_addr_i]) | (issue_regwrite_i & rd!=0 & cnt[rd]==MAX).
REQ-017 stall_o = issue_valid_i & hazard & ~flush_i; issue accepted when issue_valid_i & ~stall_o & ~flush_i.
REQ-018 Accepted issue with issue_regwrite_i and rd!=0 increments cnt[rd] at next posedge.
REQ-019 wb_RegWrite_i with wb_rd_addr_i!=0 and cnt>0 decrements that counter at next posedge.
REQ-020 Accepted issue and retire to the same index in the same cycle leave the counter unchanged.
REQ-021 Retire to an index whose counter is 0: counter stays 0, underflow_err_o set at next posedge.
REQ-022 Increment attempted at MAX cannot occur via REQ-017 (stalled); if forced by design error, counter saturates and overflow_err_o sets.
REQ-023 flush_i: all counters 0 at next posedge; overrides any same-cycle issue or retire; error flags unchanged.
REQ-024 Error flags remain set until reset.
REQ-025 busy_o and counters change only on posedge; stall_o reflects current-cycle inputs with zero latency.

Reset
REQ-026 rst_n low at posedge: all counters 0, busy_o = 0, overflow_err_o = 0, underflow_err_o = 0.
REQ-027 While rst_n low, stall_o = 0 and no issue is counted; reset overrides flush, issue and retire.
REQ-028 Reset asserted mid-operation discards all pending counts; no error flagged for later retires of discarded writes only after release (they flag underflow normally).

Configuration
REQ-029 Macro SCB_WB_BYPASS_EN defined: source hazard suppressed when same-cycle retire targets that source and its counter is 1 (register file forwarding assumed).
REQ-030 SCB_WB_BYPASS_EN undefined: hazard depends only on registered counters; same-cycle retire does not clear a stall.

Verification
REQ-031 Reset, then issue rd=5 -> next cycle busy_o=32'h0000_0020; issue rs1=5 used -> stall_o=1.
REQ-032 cnt[5]=1, wb_RegWrite_i=1 rd=5 with issue rs1=5 -> stall_o=1 without macro, 0 with macro; busy_o[5]=0 next cycle.
REQ-033 CNT_W=2, three issues to rd=7 -> cnt=3, fourth issue rd=7 -> stall_o=1, overflow_err_o stays 0.
REQ-034 Issue rd=0 and rs1=0 used -> stall_o=0, busy_o stays 0.
REQ-035 Retire rd=9 with cnt[9]=0 -> underflow_err_o=1 next cycle, held until rst_n low.
REQ-036 Issues to rd=3,4 pending, flush_i=1 with issue rd=6 -> next cycle busy_o=0, stall_o=0 during flush.
